core_mem_responder: RTL and testbench
=====================================

# core_mem_responder

Memory-side responder for the core's instruction-fetch and data-memory request interface. It answers fetches and loads/stores from a single-ported word array, returns data with fixed latency and tag echo, and arbitrates the two ports onto one memory access per cycle. It sits in the core testbench as the target connected to the core's memory interface signals.

## Interface
- MEM_WORDS, 16384: array depth in 32-bit words; byte addresses at or above MEM_WORDS*4 are out of range.
- D_LATENCY, 2: data-port cycles from accept to ack; legal values 1–4.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- mem_i_rd_w  in  1  fetch request.
- mem_i_flush_w  in  1  I-side flush request.
- mem_i_invalidate_w  in  1  I-side invalidate request.
- mem_i_pc_w  in  32  fetch byte address.
- mem_i_accept_w  out  1  I request accepted this cycle.
- mem_i_valid_w  out  1  fetch response valid.
- mem_i_error_w  out  1  fetch response error.
- mem_i_inst_w  out  32  fetched word.
- mem_d_addr_w  in  32  data byte address.
- mem_d_data_wr_w  in  32  store data.
- mem_d_rd_w  in  1  load request.
- mem_d_wr_w  in  4  store byte strobes.
- mem_d_cacheable_w  in  1  ignored; no behavioural effect.
- mem_d_req_tag_w  in  11  request tag.
- mem_d_invalidate_w, mem_d_writeback_w, mem_d_flush_w  in  1 each  cache-maintenance requests.
- mem_d_accept_w  out  1  D request accepted this cycle.
- mem_d_ack_w  out  1  data response valid.
- mem_d_error_w  out  1  data response error.
- mem_d_data_rd_w  out  32  load data.
- mem_d_resp_tag_w  out  11  echoed tag.

## Operation
- I request = rd|flush|invalidate. D request = rd|(|wr)|flush|invalidate|writeback.
- Arbiter: at most one grant per cycle. D wins unless an I request is present and streak==2, in which case I wins. streak counts consecutive D grants made while an I request was present. It increments on each such grant, saturates at 2, and clears on any I grant or on any cycle with no I request.
- accept outputs are combinational: accept = request & grant. An accept asserted with no request is never produced.
- Fetch: the memory is read at accept. Word index is pc[31:2].
  - Error if pc[1:0]!=0 or pc is out of range: inst=0, error=1.
- I flush/invalidate: accepted, no memory access, no valid response.
- D load: the memory is read at accept, so it returns data from all earlier-accepted stores.
- D store: byte lanes with wr[n]=1 are written at accept. wr[n] writes data_wr[8n+7:8n].
- D error cases, each producing error=1, data 0 and no write:
  - rd together with wr!=0.
  - address out of range.
  - address[1:0]!=0.
- D maintenance ops: ack with data 0, error 0, no memory change.
- Each accepted D request yields exactly one ack, in order, with resp_tag = req_tag. Results travel through a D_LATENCY-stage shift pipeline.
- Memory contents are not cleared by rst.

## Timing
- Fetch: valid/inst/error are registered and appear exactly 1 cycle after the accept cycle. Back-to-back fetches yield back-to-back valids.
- Data: ack appears exactly D_LATENCY cycles after the accept cycle. One accept per cycle gives one ack per cycle, with no backpressure.
- Reset values: every output 0, all pipeline stages empty, streak=0, LFSR=seed.
- Reset mid-operation: all in-flight responses are discarded; no ack or valid appears for them. Writes already accepted remain in memory.
- Simultaneous I and D requests: exactly one accept is high.
- I flush accepted in the same cycle a fetch valid is presented: the valid is still delivered.

## Configuration
- MEM_RESP_STALL_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) advances every cycle.
  - When lfsr[0]==1, both accepts are forced low. No grant is made and streak holds.
  - This stresses the core's accept handling.
- MEM_RESP_STALL_EN undefined: no LFSR exists, and accept is determined by the arbiter alone.

## Test plan
- Reset, then 3 idle cycles -> all outputs 0; no valid or ack.
- Preload word 0x10 = 32'hDEADBEEF; fetch pc=0x40 -> accept in cycle N; valid=1, inst=DEADBEEF, error=0 in cycle N+1.
- Store addr=0x100, wr=4'b0101, data=32'h11223344 over old 0xFFFFFFFF, tag=5, then a load of 0x100 with tag=6 on the next cycle -> acks in order with tags 5, 6, each D_LATENCY after its accept; load data = FF22FF44.
- I and D both request continuously for 6 cycles -> grant pattern D,D,I,D,D,I; exactly one accept per cycle.
- Load addr=0x2, then load addr=MEM_WORDS*4 -> both acks have error=1 and data 0; rd with wr=4'b0001 -> error ack and memory unchanged.
- Accept loads with tags 1 and 2, then assert rst on the cycle after the second accept -> no ack for either tag after reset; outputs 0.

Source files
------------

// File: rtl/core_mem_responder.sv
// core_mem_responder
//   Memory-side responder for the core's instruction-fetch and data-memory
//   request ports. Both ports share one single-ported word array, and at most
//   one request is granted per cycle.
//   - Fetch responses are registered and appear 1 cycle after accept.
//   - Data responses travel through a D_LATENCY-deep shift pipeline.
//     The request tag is echoed back with each response.
//
// Parameters
//   MEM_WORDS  array depth in 32-bit words
//   D_LATENCY  accept-to-ack latency of the data port (1..4)
//
// Optional feature
//   MEM_RESP_STALL_EN  when defined, a 16-bit LFSR randomly suppresses all grants
//
// Ports
//   clk, rst                              clock, synchronous active-high reset
//   mem_i_rd_w/flush_w/invalidate_w/pc_w  fetch-side request
//   mem_i_accept_w                        fetch-side accept (combinational)
//   mem_i_valid_w/error_w/inst_w          fetch response
//   mem_d_addr_w/data_wr_w/rd_w/wr_w      data-side load/store request
//   mem_d_cacheable_w                     ignored
//   mem_d_req_tag_w                       request tag
//   mem_d_invalidate_w/writeback_w/flush_w  data-side maintenance requests
//   mem_d_accept_w                        data-side accept (combinational)
//   mem_d_ack_w/error_w/data_rd_w/resp_tag_w  data response
module core_mem_responder #(
   parameter int MEM_WORDS = 16384,
   parameter int D_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_i_rd_w,
   input  logic        mem_i_flush_w,
   input  logic        mem_i_invalidate_w,
   input  logic [31:0] mem_i_pc_w,
   output logic        mem_i_accept_w,
   output logic        mem_i_valid_w,
   output logic        mem_i_error_w,
   output logic [31:0] mem_i_inst_w,
   input  logic [31:0] mem_d_addr_w,
   input  logic [31:0] mem_d_data_wr_w,
   input  logic        mem_d_rd_w,
   input  logic [3:0]  mem_d_wr_w,
   input  logic        mem_d_cacheable_w,
   input  logic [10:0] mem_d_req_tag_w,
   input  logic        mem_d_invalidate_w,
   input  logic        mem_d_writeback_w,
   input  logic        mem_d_flush_w,
   output logic        mem_d_accept_w,
   output logic        mem_d_ack_w,
   output logic        mem_d_error_w,
   output logic [31:0] mem_d_data_rd_w,
   output logic [10:0] mem_d_resp_tag_w
);

   localparam int          IDX_W     = $clog2(MEM_WORDS);
   localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

   logic [31:0] mem [MEM_WORDS];

   logic        i_req, d_req, stall;
   logic        grant_i, grant_d;
   logic [1:0]  streak_q, streak_d;

   logic        unused_cacheable;
   assign unused_cacheable = mem_d_cacheable_w;

   assign i_req = mem_i_rd_w | mem_i_flush_w | mem_i_invalidate_w;
   assign d_req = mem_d_rd_w | (|mem_d_wr_w) | mem_d_flush_w |
                  mem_d_invalidate_w | mem_d_writeback_w;

`ifdef MEM_RESP_STALL_EN
   // Fibonacci LFSR, taps 16,14,13,11; a set LSB stalls both ports this cycle.
   logic [15:0] lfsr_q;
   always_ff @(posedge clk) begin
      if (rst) lfsr_q <= 16'hACE1;
      else     lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end
   assign stall = lfsr_q[0];
`else
   assign stall = 1'b0;
`endif

   // Arbiter: D has priority, but after two D grants made while an I request
   // was waiting, the waiting I request is granted.
   always_comb begin
      grant_i  = 1'b0;
      grant_d  = 1'b0;
      streak_d = streak_q;
      if (!stall) begin
         if (i_req && (!d_req || streak_q == 2'd2)) grant_i = 1'b1;
         else if (d_req)                             grant_d = 1'b1;

         if (!i_req || grant_i)               streak_d = 2'd0;
         else if (grant_d && streak_q != 2'd2) streak_d = streak_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) streak_q <= 2'd0;
      else     streak_q <= streak_d;
   end

   assign mem_i_accept_w = grant_i;
   assign mem_d_accept_w = grant_d;

   // Request decode and the single shared array access.
   logic [IDX_W-1:0] i_idx, d_idx, acc_idx;
   logic             i_bad, i_fetch;
   logic             d_store, d_bad_addr, d_err, d_wr_en, d_load_ok;
   logic [31:0]      rd_word;

   assign i_idx   = mem_i_pc_w[IDX_W+1:2];
   assign i_bad   = (|mem_i_pc_w[1:0]) | ({1'b0, mem_i_pc_w} >= MEM_BYTES);
   assign i_fetch = grant_i & mem_i_rd_w;

   assign d_idx      = mem_d_addr_w[IDX_W+1:2];
   assign d_store    = |mem_d_wr_w;
   assign d_bad_addr = (|mem_d_addr_w[1:0]) | ({1'b0, mem_d_addr_w} >= MEM_BYTES);
   assign d_err      = (mem_d_rd_w & d_store) | ((mem_d_rd_w | d_store) & d_bad_addr);
   assign d_wr_en    = grant_d & d_store & ~d_err;
   assign d_load_ok  = grant_d & mem_d_rd_w & ~d_err;

   assign acc_idx = grant_i ? i_idx : d_idx;
   assign rd_word = mem[acc_idx];

   // Array contents survive reset.
   always_ff @(posedge clk) begin
      if (d_wr_en) begin
         for (int n = 0; n < 4; n++) begin
            if (mem_d_wr_w[n]) mem[d_idx][8*n +: 8] <= mem_d_data_wr_w[8*n +: 8];
         end
      end
   end

   // ---- fetch response stage (p0) ----
   logic        i_vld_p0, i_err_p0;
   logic [31:0] i_inst_p0;

   always_ff @(posedge clk) begin
      if (rst) begin
         i_vld_p0  <= 1'b0;
         i_err_p0  <= 1'b0;
         i_inst_p0 <= 32'd0;
      end else begin
         i_vld_p0  <= i_fetch;
         i_err_p0  <= i_fetch & i_bad;
         i_inst_p0 <= (i_fetch && !i_bad) ? rd_word : 32'd0;
      end
   end

   assign mem_i_valid_w = i_vld_p0;
   assign mem_i_error_w = i_err_p0;
   assign mem_i_inst_w  = i_inst_p0;

   // ---- data response pipeline, stages p0 .. p(D_LATENCY-1) ----
   logic        d_vld_p  [D_LATENCY];
   logic        d_err_p  [D_LATENCY];
   logic [31:0] d_data_p [D_LATENCY];
   logic [10:0] d_tag_p  [D_LATENCY];

   // Data stages are cleared by reset too, so every output reads 0 after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < D_LATENCY; s++) begin
            d_vld_p[s]  <= 1'b0;
            d_err_p[s]  <= 1'b0;
            d_data_p[s] <= 32'd0;
            d_tag_p[s]  <= 11'd0;
         end
      end else begin
         d_vld_p[0]  <= grant_d;
         d_err_p[0]  <= grant_d & d_err;
         d_data_p[0] <= d_load_ok ? rd_word : 32'd0;
         d_tag_p[0]  <= grant_d ? mem_d_req_tag_w : 11'd0;
         for (int s = 1; s < D_LATENCY; s++) begin
            d_vld_p[s]  <= d_vld_p[s-1];
            d_err_p[s]  <= d_err_p[s-1];
            d_data_p[s] <= d_data_p[s-1];
            d_tag_p[s]  <= d_tag_p[s-1];
         end
      end
   end

   assign mem_d_ack_w      = d_vld_p[D_LATENCY-1];
   assign mem_d_error_w    = d_err_p[D_LATENCY-1];
   assign mem_d_data_rd_w  = d_data_p[D_LATENCY-1];
   assign mem_d_resp_tag_w = d_tag_p[D_LATENCY-1];

endmodule

// File: tb/tb_core_mem_responder.sv
module tb_core_mem_responder;
   localparam int MEM_WORDS = 16384;
   localparam int D_LATENCY = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_i_rd_w = 0, mem_i_flush_w = 0, mem_i_invalidate_w = 0;
   logic [31:0] mem_i_pc_w = 0;
   logic        mem_i_accept_w, mem_i_valid_w, mem_i_error_w;
   logic [31:0] mem_i_inst_w;
   logic [31:0] mem_d_addr_w = 0, mem_d_data_wr_w = 0;
   logic        mem_d_rd_w = 0;
   logic [3:0]  mem_d_wr_w = 0;
   logic        mem_d_cacheable_w = 0;
   logic [10:0] mem_d_req_tag_w = 0;
   logic        mem_d_invalidate_w = 0, mem_d_writeback_w = 0, mem_d_flush_w = 0;
   logic        mem_d_accept_w, mem_d_ack_w, mem_d_error_w;
   logic [31:0] mem_d_data_rd_w;
   logic [10:0] mem_d_resp_tag_w;

   core_mem_responder #(.MEM_WORDS(MEM_WORDS), .D_LATENCY(D_LATENCY)) dut (
      .clk(clk), .rst(rst),
      .mem_i_rd_w(mem_i_rd_w), .mem_i_flush_w(mem_i_flush_w),
      .mem_i_invalidate_w(mem_i_invalidate_w), .mem_i_pc_w(mem_i_pc_w),
      .mem_i_accept_w(mem_i_accept_w), .mem_i_valid_w(mem_i_valid_w),
      .mem_i_error_w(mem_i_error_w), .mem_i_inst_w(mem_i_inst_w),
      .mem_d_addr_w(mem_d_addr_w), .mem_d_data_wr_w(mem_d_data_wr_w),
      .mem_d_rd_w(mem_d_rd_w), .mem_d_wr_w(mem_d_wr_w),
      .mem_d_cacheable_w(mem_d_cacheable_w), .mem_d_req_tag_w(mem_d_req_tag_w),
      .mem_d_invalidate_w(mem_d_invalidate_w), .mem_d_writeback_w(mem_d_writeback_w),
      .mem_d_flush_w(mem_d_flush_w), .mem_d_accept_w(mem_d_accept_w),
      .mem_d_ack_w(mem_d_ack_w), .mem_d_error_w(mem_d_error_w),
      .mem_d_data_rd_w(mem_d_data_rd_w), .mem_d_resp_tag_w(mem_d_resp_tag_w)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        err;
      logic [31:0] data;
      logic [10:0] tag;
      int          due;
   } exp_t;

   exp_t d_q[$];
   exp_t i_q[$];
   logic [31:0] ref_mem [int unsigned];
   logic [31:0] last_d_data = 0;
   logic [10:0] last_d_tag  = 0;
   logic [31:0] last_i_inst = 0;

   int unsigned pool [8] = '{32'h10, 32'h40, 32'h41, 32'h42, 32'h43, 32'h44, 32'h45, MEM_WORDS - 1};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic bit addr_bad(input logic [31:0] a);
      return (a % 4 != 0) || (longint'(a) >= longint'(MEM_WORDS) * 4);
   endfunction

   // Reference model of a data request: what the response must be, and the
   // effect on memory of a legal store.
   function automatic exp_t model_d(input logic rd, input logic [3:0] wr,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [10:0] tag);
      exp_t e;
      int unsigned w;
      logic [31:0] word, lane;
      e.err = 0; e.data = 0; e.tag = tag; e.due = cyc + D_LATENCY;
      w = addr / 4;
      if (rd && wr != 0)                   e.err = 1;
      else if ((rd || wr != 0) && addr_bad(addr)) e.err = 1;
      else if (rd)                         e.data = ref_mem[w];
      else if (wr != 0) begin
         word = ref_mem.exists(w) ? ref_mem[w] : 32'd0;
         for (int n = 0; n < 4; n++) begin
            lane = 32'hFF << (8 * n);
            if (wr[n]) word = (word & ~lane) | (wdata & lane);
         end
         ref_mem[w] = word;
      end
      return e;
   endfunction

   function automatic exp_t model_i(input logic [31:0] pc);
      exp_t e;
      e.tag = 0; e.due = cyc + 1;
      e.err = addr_bad(pc);
      e.data = e.err ? 32'd0 : ref_mem[pc / 4];
      return e;
   endfunction

   // Stimulus side of the scoreboard: each accepted request pushes its expectation.
   always @(negedge clk) begin
      logic ireq, dreq;
      if (!rst) begin
         ireq = mem_i_rd_w | mem_i_flush_w | mem_i_invalidate_w;
         dreq = mem_d_rd_w | (|mem_d_wr_w) | mem_d_flush_w | mem_d_invalidate_w | mem_d_writeback_w;
         if ((mem_i_accept_w && !ireq) || (mem_d_accept_w && !dreq)) begin
            tests++; fails++;
            $display("FAIL spurious_accept: i_acc=%0b d_acc=%0b with i_req=%0b d_req=%0b", mem_i_accept_w, mem_d_accept_w, ireq, dreq);
         end
         if (ireq && dreq)
            check("one_accept", 64'(mem_i_accept_w + mem_d_accept_w), 64'd1);
         if (mem_d_accept_w)
            d_q.push_back(model_d(mem_d_rd_w, mem_d_wr_w, mem_d_addr_w, mem_d_data_wr_w, mem_d_req_tag_w));
         if (mem_i_accept_w && mem_i_rd_w)
            i_q.push_back(model_i(mem_i_pc_w));
      end
   end

   // Monitor: pops and compares whenever the DUT presents a response.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         d_q.delete();
         i_q.delete();
      end else begin
         if (mem_d_ack_w) begin
            last_d_data = mem_d_data_rd_w;
            last_d_tag  = mem_d_resp_tag_w;
            if (d_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_ack: tag %0h at cycle %0d, none expected", mem_d_resp_tag_w, cyc);
            end else begin
               e = d_q.pop_front();
               check("d_tag",   64'(mem_d_resp_tag_w), 64'(e.tag));
               check("d_error", 64'(mem_d_error_w),    64'(e.err));
               check("d_data",  64'(mem_d_data_rd_w),  64'(e.data));
               check("d_latency_cycle", 64'(cyc), 64'(e.due));
            end
         end else if (d_q.size() != 0 && d_q[0].due <= cyc) begin
            e = d_q.pop_front();
            tests++; fails++;
            $display("FAIL missing_ack: tag %0h due cycle %0d, no ack by %0d", e.tag, e.due, cyc);
         end
         if (mem_i_valid_w) begin
            last_i_inst = mem_i_inst_w;
            if (i_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_valid: inst %0h at cycle %0d, none expected", mem_i_inst_w, cyc);
            end else begin
               e = i_q.pop_front();
               check("i_error", 64'(mem_i_error_w), 64'(e.err));
               check("i_inst",  64'(mem_i_inst_w),  64'(e.data));
               check("i_latency_cycle", 64'(cyc), 64'(e.due));
            end
         end else if (i_q.size() != 0 && i_q[0].due <= cyc) begin
            e = i_q.pop_front();
            tests++; fails++;
            $display("FAIL missing_valid: fetch due cycle %0d, no valid by %0d", e.due, cyc);
         end
      end
   end

   task automatic clear_d;
      mem_d_rd_w = 0; mem_d_wr_w = 0; mem_d_flush_w = 0;
      mem_d_invalidate_w = 0; mem_d_writeback_w = 0;
   endtask

   task automatic clear_i;
      mem_i_rd_w = 0; mem_i_flush_w = 0; mem_i_invalidate_w = 0;
   endtask

   // Starts and ends just after a rising edge; holds each request until accepted.
   task automatic issue(input bit do_d, input logic d_rd, input logic [3:0] d_wr,
                        input logic [31:0] d_addr, input logic [31:0] d_data,
                        input logic [10:0] d_tag, input logic [2:0] d_mnt,
                        input bit do_i, input logic i_rd, input logic i_fl,
                        input logic i_inv, input logic [31:0] i_pc);
      bit pend_d, pend_i, acc_d, acc_i;
      int n;
      pend_d = do_d; pend_i = do_i; n = 0;
      if (do_d) begin
         mem_d_rd_w = d_rd; mem_d_wr_w = d_wr; mem_d_addr_w = d_addr;
         mem_d_data_wr_w = d_data; mem_d_req_tag_w = d_tag;
         {mem_d_invalidate_w, mem_d_writeback_w, mem_d_flush_w} = d_mnt;
         mem_d_cacheable_w = 1'($urandom);
      end
      if (do_i) begin
         mem_i_rd_w = i_rd; mem_i_flush_w = i_fl; mem_i_invalidate_w = i_inv; mem_i_pc_w = i_pc;
      end
      while ((pend_d || pend_i) && n < 50) begin
         @(negedge clk);
         acc_d = mem_d_accept_w; acc_i = mem_i_accept_w;
         @(posedge clk); #1;
         n++;
         if (pend_d && acc_d) begin clear_d(); pend_d = 0; end
         if (pend_i && acc_i) begin clear_i(); pend_i = 0; end
      end
      if (pend_d || pend_i) begin
         tests++; fails++;
         $display("FAIL accept_timeout: pending d=%0b i=%0b after %0d cycles", pend_d, pend_i, n);
         clear_d(); clear_i();
      end
   endtask

   task automatic d_op(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [10:0] tag);
      issue(1, rd, wr, addr, data, tag, 3'b000, 0, 0, 0, 0, 0);
   endtask

   task automatic fetch(input logic [31:0] pc);
      issue(0, 0, 0, 0, 0, 0, 3'b000, 1, 1, 0, 0, pc);
   endtask

   task automatic idle_check(input int n, input string name);
      repeat (n) begin
         @(negedge clk);
         check(name, 64'({mem_i_accept_w, mem_i_valid_w, mem_i_error_w, mem_i_inst_w}), 64'd0);
         check(name, 64'({mem_d_accept_w, mem_d_ack_w, mem_d_error_w, mem_d_data_rd_w, mem_d_resp_tag_w}), 64'd0);
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      string pat;
      logic [31:0] a;
      int k;

      repeat (3) @(posedge clk);
      #1 rst = 0;
      idle_check(3, "reset_idle");

      // Preload the address pool with known contents.
      for (int p = 0; p < 8; p++) d_op(0, 4'hF, pool[p] * 4, $urandom, 11'(p));
      d_op(0, 4'hF, 32'h40, 32'hDEADBEEF, 11'h7);
      d_op(0, 4'hF, 32'h100, 32'hFFFFFFFF, 11'h8);
      wait_cycles(D_LATENCY + 1);

      // Fetch of a preloaded word.
      fetch(32'h40);
      wait_cycles(2);
      check("fetch_deadbeef", 64'(last_i_inst), 64'hDEADBEEF);

      // Partial store then load on the following cycle.
      d_op(0, 4'b0101, 32'h100, 32'h11223344, 11'd5);
      d_op(1, 4'b0000, 32'h100, 32'h0, 11'd6);
      wait_cycles(D_LATENCY + 1);
      check("merged_load_data", 64'(last_d_data), 64'hFF22FF44);
      check("merged_load_tag",  64'(last_d_tag),  64'd6);

      // Arbitration with both ports requesting continuously.
      wait_cycles(1);
      mem_i_rd_w = 1; mem_i_pc_w = 32'h40;
      mem_d_flush_w = 1; mem_d_req_tag_w = 11'h3A;
      pat = "";
      repeat (6) begin
         @(negedge clk);
         pat = {pat, mem_d_accept_w ? "D" : (mem_i_accept_w ? "I" : "-")};
         @(posedge clk); #1;
      end
      clear_i(); clear_d();
      tests++;
      if (pat != "DDIDDI") begin
         fails++;
         $display("FAIL grant_pattern: got %s expected DDIDDI", pat);
      end

      // Error cases and an erroneous rd+wr that must leave memory intact.
      d_op(1, 4'b0000, 32'h2, 0, 11'd20);
      d_op(1, 4'b0000, MEM_WORDS * 4, 0, 11'd21);
      d_op(1, 4'b0001, 32'h104, 32'h000000AA, 11'd22);
      d_op(1, 4'b0000, 32'h104, 0, 11'd23);
      issue(1, 0, 0, 32'h0, 0, 11'd24, 3'b010, 0, 0, 0, 0, 0);
      fetch(32'h42);
      fetch(MEM_WORDS * 4);
      wait_cycles(D_LATENCY + 1);

      // Randomized mix of requests on both ports.
      for (int it = 0; it < 300; it++) begin
         bit do_d, do_i, rd, ifl, iinv, ird;
         logic [3:0] wr;
         logic [2:0] mnt;
         logic [31:0] pc;
         do_d = ($urandom % 4) != 0;
         do_i = ($urandom % 3) == 0;
         if (!do_d && !do_i) do_d = 1;
         rd = 0; wr = 0; mnt = 0;
         a = pool[$urandom % 8] * 4;
         k = $urandom % 8;
         case (k)
            0, 1, 2: wr = 4'($urandom_range(1, 15));
            3, 4:    rd = 1;
            5: begin
               rd = 1;
               if ($urandom % 2) a = a + 32'($urandom_range(1, 3));
               else a = MEM_WORDS * 4 + ($urandom % 64) * 4;
            end
            6: begin rd = 1; wr = 4'($urandom_range(1, 15)); end
            default: mnt = 3'b001 << ($urandom % 3);
         endcase
         ird = 0; ifl = 0; iinv = 0;
         pc = pool[$urandom % 8] * 4;
         k = $urandom % 8;
         case (k)
            0, 1, 2, 3: ird = 1;
            4: begin ird = 1; pc = pc + 32'($urandom_range(1, 3)); end
            5: begin ird = 1; pc = 32'hFFFFFFFC; end
            6: ifl = 1;
            default: iinv = 1;
         endcase
         issue(do_d, rd, wr, a, $urandom, 11'($urandom), mnt, do_i, ird, ifl, iinv, pc);
      end
      wait_cycles(D_LATENCY + 2);

      // Reset while two loads are in flight: neither may be acknowledged.
      d_op(1, 0, pool[1] * 4, 0, 11'd1);
      d_op(1, 0, pool[2] * 4, 0, 11'd2);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      idle_check(4, "post_reset_idle");

      k = 0;
      while ((d_q.size() != 0 || i_q.size() != 0) && k < 20) begin
         @(posedge clk); k++;
      end
      check("queues_drained", 64'(d_q.size() + i_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
